// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Owns the fetch PC, drives a req/ready instruction-memory handshake that
// tolerates wait states, and feeds decode with real instructions or bubbles.
// A fetch whose PC a taken branch has made stale is completed, then dropped.
module fetch_stage #(
  parameter int unsigned          ADDR_W   = 16,
  parameter int unsigned          DATA_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = 16'h0000,
  parameter logic [DATA_W-1:0]    NOP      = 16'h0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              InstBranch,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] pcF,
  output logic [DATA_W-1:0] instrD,
  output logic [ADDR_W-1:0] pcD,
  output logic              validD
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   pcf_q, pcf_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                kill_q, kill_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [DATA_W-1:0]   instrd_q, instrd_d;
  logic [ADDR_W-1:0]   pcd_q, pcd_d;
  logic                validd_q, validd_d;

  logic                deliver_s;
  logic [DATA_W-1:0]   dlv_data_s;
  logic [ADDR_W-1:0]   addr_inc_s;

  // Next word address; wraps modulo 2^ADDR_W.
  assign addr_inc_s = addr_q + ADDR_W'(1);

  // Fetch FSM: next state, fetch PC, request address, stale-fetch kill and hold buffer.
  always_comb begin
    state_d    = state_q;
    pcf_d      = pcf_q;
    addr_d     = addr_q;
    kill_d     = kill_q;
    buf_d      = buf_q;
    deliver_s  = 1'b0;
    dlv_data_s = imem_rdata;
    case (state_q)
      IDLE: begin
        if (InstBranch) begin
          pcf_d = branch_target;
        end else if (!stallF) begin
          addr_d  = pcf_q;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (imem_ready) begin
          if (kill_q || InstBranch) begin
            // Completed fetch is stale: drop the data, follow the redirect.
            kill_d  = 1'b0;
            state_d = IDLE;
            if (InstBranch) begin
              pcf_d = branch_target;
            end else begin
              pcf_d = pcf_q;
            end
          end else if (stallD || flushD) begin
            // Decode cannot take it now; park it so it is never lost.
            buf_d   = imem_rdata;
            state_d = HOLD;
          end else begin
            deliver_s  = 1'b1;
            dlv_data_s = imem_rdata;
            pcf_d      = addr_inc_s;
            if (!stallF) begin
              addr_d = addr_inc_s;
            end else begin
              state_d = IDLE;
            end
          end
        end else if (InstBranch) begin
          // Request must stay stable, so remember to discard its data.
          pcf_d  = branch_target;
          kill_d = 1'b1;
        end else begin
          state_d = BUSY;
        end
      end
      HOLD: begin
        if (InstBranch) begin
          pcf_d   = branch_target;
          state_d = IDLE;
        end else if (!stallD && !flushD) begin
          deliver_s  = 1'b1;
          dlv_data_s = buf_q;
          pcf_d      = addr_inc_s;
          state_d    = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
    endcase
    req_d = (state_d == BUSY);
  end

  // IF/ID register next values: flush beats stall beats delivery beats bubble.
  always_comb begin
    instrd_d = instrd_q;
    pcd_d    = pcd_q;
    validd_d = validd_q;
    if (flushD) begin
      instrd_d = NOP;
      validd_d = 1'b0;
    end else if (stallD) begin
      instrd_d = instrd_q;
    end else if (deliver_s) begin
      instrd_d = dlv_data_s;
      pcd_d    = addr_q;
      validd_d = 1'b1;
    end else begin
      instrd_d = NOP;
      validd_d = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      pcf_q    <= RESET_PC;
      addr_q   <= RESET_PC;
      kill_q   <= 1'b0;
      buf_q    <= NOP;
      instrd_q <= NOP;
      pcd_q    <= {ADDR_W{1'b0}};
      validd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      pcf_q    <= pcf_d;
      addr_q   <= addr_d;
      kill_q   <= kill_d;
      buf_q    <= buf_d;
      instrd_q <= instrd_d;
      pcd_q    <= pcd_d;
      validd_q <= validd_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign pcF       = pcf_q;
  assign instrD    = instrd_q;
  assign pcD       = pcd_q;
  assign validD    = validd_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage and IF/ID pipeline register of the 16-bit CPU. It acts on the stall, flush and branch-redirect controls that the hazard unit issues. It owns the fetch PC and drives a req/ready instruction-memory handshake that tolerates wait states. It delivers instructions to decode, inserts bubbles when needed, and discards fetches that a taken branch has made stale.

Parameters:
ADDR_W, 16, PC / instruction-memory address width
DATA_W, 16, instruction width
RESET_PC, 16'h0000, PC value after reset
NOP, 16'h0000, encoding driven on instrD for a bubble

Ports:
clk  input  1  clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
stallF  input  1  hazard unit: do not launch a new fetch
stallD  input  1  hazard unit: hold the IF/ID register
flushD  input  1  hazard unit: clear the IF/ID register to a bubble
InstBranch  input  1  taken-branch redirect
branch_target  input  ADDR_W  redirect PC, valid when InstBranch=1
imem_req  output  1  instruction fetch request
imem_addr  output  ADDR_W  fetch address, stable while imem_req=1
imem_rdata  input  DATA_W  instruction, valid in the cycle imem_ready=1
imem_ready  input  1  fetch complete
pcF  output  ADDR_W  current fetch PC
instrD  output  DATA_W  IF/ID instruction
pcD  output  ADDR_W  IF/ID PC of instrD
validD  output  1  instrD is a real instruction

Behaviour:
- Reset values: pcF=RESET_PC, imem_req=0, imem_addr=RESET_PC, instrD=NOP, pcD=0, validD=0, kill=0, state=IDLE. Reset mid-request drops the request with no completion owed.
- Request rule: once imem_req rises, imem_req and imem_addr stay stable until the cycle imem_ready=1. A request is never withdrawn early. imem_ready is ignored while imem_req=0.
- FSM IDLE (imem_req=0):
  - InstBranch: pcF<=branch_target; stay in IDLE.
  - Otherwise, if !stallF: imem_addr<=pcF; go to BUSY.
- FSM BUSY (imem_req=1):
  - InstBranch while !imem_ready: pcF<=branch_target, kill<=1.
  - On imem_ready with (kill | InstBranch): discard the data; kill<=0; pcF<=branch_target if InstBranch; go to IDLE.
  - On imem_ready with (stallD | flushD): buf<=imem_rdata; go to HOLD.
  - On imem_ready otherwise: deliver the instruction. pcF<=imem_addr+1.
    - If !stallF: imem_addr<=imem_addr+1 and stay in BUSY (back-to-back fetch).
    - Otherwise go to IDLE.
- FSM HOLD (imem_req=0):
  - InstBranch: drop buf; pcF<=branch_target; go to IDLE.
  - Else if !stallD & !flushD: deliver buf; pcF<=imem_addr+1; go to IDLE.
- Deliver: instrD<=data, pcD<=imem_addr, validD<=1.
- IF/ID register priority each cycle: flushD > stallD > deliver > bubble.
  - flushD: instrD<=NOP, validD<=0; pcD holds.
  - stallD: all IF/ID outputs hold.
  - No delivery: instrD<=NOP, validD<=0.
- Redirect beats stallF on pcF. A held buf is never lost except through InstBranch.
- Throughput with a zero-wait memory (imem_ready tied high while req): one instruction per cycle after a 2-cycle start-up from IDLE.
- Arithmetic: PC increments by 1 (word addressed), modulo 2^ADDR_W, so 16'hFFFF+1 = 16'h0000.

Test Plan:
- Reset, then zero-wait memory returning data = address^16'hA5A5 -> imem_addr 0,1,2,… on consecutive cycles; validD=1 from cycle 3 with pcD 0,1,2,… and instrD matching.
- imem_ready delayed 3 cycles per request -> imem_addr stable during the wait; validD=0 (instrD=NOP) during waits; each instruction delivered exactly once, in order.
- stallD=stallF=1 for 4 cycles, asserted in the cycle imem_ready=1 at addr 5 -> instruction 5 goes to HOLD; instrD/pcD hold; after release, pcD=5 is delivered, then the fetch of 6 starts.
- InstBranch=1 with target 16'h0040, one cycle into a 3-cycle wait at addr 9 -> imem_addr stays 9 until ready; the data is discarded (validD stays 0); the next request is at 16'h0040.
- InstBranch=flushD=stallD=stallF=1 in the cycle imem_ready=1 at addr 12 -> validD<=0, instrD=NOP, addr 12 never delivered, pcF=target.
- RESET_PC=16'hFFFE with a zero-wait stream -> pcD sequence FFFE, FFFF, 0000, 0001; reset_n pulsed low mid-BUSY -> imem_req=0 immediately and all outputs at reset values.
